// File: rtl/digit_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_ctrl_pkg
// Purpose  : Shared state encoding, digit geometry and sizing helper for the
//            digit scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package digit_scan_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BLANK  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_ctrl_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_ctrl_scan_timer
// Purpose  : Loadable down-counter timing one BLANK or ACTIVE period; flags
//            the final cycle of the period now and on the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl_scan_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc,
    output logic             tc_nxt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counts load_val..1; a count of 1 marks the last cycle of the period.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc     = (cnt_q == CNT_W'(1));
    assign tc_nxt = (cnt_d == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_ctrl
// Purpose  : Steps a 2-bit digit select and gates the 2-to-4 decoder enable
//            with a blanking gap and an active period per digit slot.
//            Optional macro DIGIT_SCAN_DIR_EN adds a scan-direction input.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int ACTIVE_CYC = 8,
    parameter int BLANK_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       mask,
`ifdef DIGIT_SCAN_DIR_EN
    input  logic             dir,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             digit_done,
    output logic             frame_done
);

    localparam int               CNT_W  = $clog2(max2(ACTIVE_CYC, BLANK_CYC) + 1);
    localparam logic [CNT_W-1:0] ACT_LD = CNT_W'(ACTIVE_CYC);
    localparam logic [CNT_W-1:0] BLK_LD = CNT_W'(BLANK_CYC);

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       mask_q, mask_d;
    logic             en_q, en_d;
    logic             digit_done_q, digit_done_d;
    logic             frame_done_q, frame_done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_tc;
    logic             tmr_tc_nxt;

    logic [SEL_W-1:0] start_sel;
    logic [SEL_W-1:0] step_sel;
    logic [SEL_W-1:0] last_sel;

`ifdef DIGIT_SCAN_DIR_EN
    logic dir_q, dir_d;

    // Direction is latched whenever the next slot index is chosen.
    always_comb begin
        dir_d = dir_q;
        if (((state_q == ST_IDLE) && run) || ((state_q == ST_ACTIVE) && tmr_tc)) begin
            dir_d = dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign start_sel = dir   ? SEL_W'(NUM_DIGITS - 1) : '0;
    assign step_sel  = dir   ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
    assign last_sel  = dir_d ? '0 : SEL_W'(NUM_DIGITS - 1);
`else
    assign start_sel = '0;
    assign step_sel  = sel_q + SEL_W'(1);
    assign last_sel  = SEL_W'(NUM_DIGITS - 1);
`endif

    digit_scan_ctrl_scan_timer #(
        .CNT_W (CNT_W)
    ) u_scan_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tc       (tmr_tc),
        .tc_nxt   (tmr_tc_nxt)
    );

    // State register; outputs are registered from next-state values so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            mask_q       <= '0;
            en_q         <= 1'b0;
            digit_done_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            en_q         <= en_d;
            digit_done_q <= digit_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        mask_d       = mask_q;
        tmr_load     = 1'b0;
        tmr_load_val = ACT_LD;
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (run) begin
                    sel_d    = start_sel;
                    tmr_load = 1'b1;
                    if (BLANK_CYC > 0) begin
                        state_d      = ST_BLANK;
                        tmr_load_val = BLK_LD;
                    end else begin
                        state_d = ST_ACTIVE;
                        mask_d  = mask;
                    end
                end
            end
            ST_BLANK: begin
                if (!run) begin
                    state_d      = ST_IDLE;
                    sel_d        = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else if (tmr_tc) begin
                    state_d  = ST_ACTIVE;
                    mask_d   = mask;
                    tmr_load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // A slot always runs to completion; run only decides what follows.
                if (tmr_tc) begin
                    sel_d    = step_sel;
                    tmr_load = 1'b1;
                    if (!run) begin
                        state_d      = ST_IDLE;
                        sel_d        = '0;
                        tmr_load_val = '0;
                    end else if (BLANK_CYC > 0) begin
                        state_d      = ST_BLANK;
                        tmr_load_val = BLK_LD;
                    end else begin
                        state_d = ST_ACTIVE;
                        mask_d  = mask;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d         = (state_d == ST_ACTIVE) && mask_d[sel_d];
        digit_done_d = (state_d == ST_ACTIVE) && tmr_tc_nxt;
        frame_done_d = digit_done_d && (sel_d == last_sel);
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign digit_done = digit_done_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_ctrl
// Purpose  : Randomized self-checking bench for digit_scan_ctrl (default and
//            BLANK_CYC=0/ACTIVE_CYC=1 instances) against a slot-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_ctrl;

    localparam int B0 = 2;
    localparam int A0 = 8;
    localparam int B1 = 0;
    localparam int A1 = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       run   = 1'b0;
    logic [3:0] mask  = 4'h0;

    logic [1:0] sel, f_sel;
    logic       en, dd, fd, f_en, f_dd, f_fd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    digit_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
        .sel        (sel),
        .en         (en),
        .digit_done (dd),
        .frame_done (fd)
    );

    digit_scan_ctrl #(
        .ACTIVE_CYC (A1),
        .BLANK_CYC  (B1)
    ) dut_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
        .sel        (f_sel),
        .en         (f_en),
        .digit_done (f_dd),
        .frame_done (f_fd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each instance is either stopped, or sits at position
    // pos within a slot of B blank cycles followed by A active cycles.
    int         m_on   [2];
    int         m_slot [2];
    int         m_pos  [2];
    logic [3:0] m_mask [2];

    function automatic int pb(input int i);
        return (i == 0) ? B0 : B1;
    endfunction

    function automatic int pa(input int i);
        return (i == 0) ? A0 : A1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int on, slot, pos, b, a;
        logic [3:0] mk;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_on[i]   <= 0;
                m_slot[i] <= 0;
                m_pos[i]  <= 0;
                m_mask[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                on = m_on[i]; slot = m_slot[i]; pos = m_pos[i]; mk = m_mask[i];
                b = pb(i); a = pa(i);
                if (on == 0) begin
                    if (run) begin
                        on = 1; slot = 0; pos = 0;
                        if (b == 0) mk = mask;
                    end
                end else if (pos < b) begin
                    if (!run) begin
                        on = 0; slot = 0; pos = 0;
                    end else begin
                        pos = pos + 1;
                        if (pos == b) mk = mask;
                    end
                end else if (pos == b + a - 1) begin
                    slot = (slot + 1) % 4;
                    pos  = 0;
                    if (!run) begin
                        on = 0; slot = 0;
                    end else if (b == 0) begin
                        mk = mask;
                    end
                end else begin
                    pos = pos + 1;
                end
                m_on[i] <= on; m_slot[i] <= slot; m_pos[i] <= pos; m_mask[i] <= mk;
            end
        end
    end

    function automatic logic [4:0] exp_one(input int i);
        logic [1:0] s;
        logic e, d, f;
        s = (m_on[i] != 0) ? 2'(m_slot[i]) : 2'd0;
        e = (m_on[i] != 0) && (m_pos[i] >= pb(i)) && m_mask[i][m_slot[i]];
        d = (m_on[i] != 0) && (m_pos[i] == pb(i) + pa(i) - 1);
        f = d && (m_slot[i] == 3);
        return {s, e, d, f};
    endfunction

    function automatic logic [9:0] exp_vec();
        return {exp_one(0), exp_one(1)};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== 10'b0) begin
            errors++;
            $display("FAIL reset got=%b exp=%b", {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_scan();
        int c_set, c_en, last_fd;
        c_en = -1; last_fd = -1;
        mask = 4'hF;
        run  = 1'b1;
        c_set = cyc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL full_scan cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
            if (en && c_en < 0) c_en = cyc;
            if (fd) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != 4 * (B0 + A0)) begin
                        errors++;
                        $display("FAIL frame_period got=%0d exp=%0d", cyc - last_fd, 4 * (B0 + A0));
                    end
                end
                last_fd = cyc;
            end
        end
        checks++;
        if (c_en - c_set != B0 + 1) begin
            errors++;
            $display("FAIL first_en_latency got=%0d exp=%0d", c_en - c_set, B0 + 1);
        end
    endtask

    task automatic test_masked();
        int last_dd, odd_en;
        last_dd = -1; odd_en = 0;
        mask = 4'b0101;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL masked cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
            if (k >= 20 && en && sel[0]) odd_en++;
            if (dd) begin
                if (last_dd >= 0) begin
                    checks++;
                    if (cyc - last_dd != B0 + A0) begin
                        errors++;
                        $display("FAIL digit_period got=%0d exp=%0d", cyc - last_dd, B0 + A0);
                    end
                end
                last_dd = cyc;
            end
        end
        checks++;
        if (odd_en != 0) begin
            errors++;
            $display("FAIL masked_odd_slots en_cycles=%0d exp=0", odd_en);
        end
    endtask

    task automatic test_run_drop_active();
        int pulses, k;
        pulses = 0;
        k = 0;
        while (k < 200 && !(m_on[0] != 0 && m_slot[0] == 1 && m_pos[0] == B0 + 3)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL drop_active_wait timeout got=%0d exp<200", k);
        end
        run = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL drop_active cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
            if (dd) pulses++;
        end
        checks++;
        if (pulses != 1 || sel !== 2'd0 || en !== 1'b0) begin
            errors++;
            $display("FAIL drop_active_idle got pulses=%0d sel=%0d en=%b exp pulses=1 sel=0 en=0", pulses, sel, en);
        end
    endtask

    task automatic test_run_drop_blank();
        int k, slot2_en;
        k = 0; slot2_en = 0;
        run = 1'b1;
        while (k < 200 && !(m_on[0] != 0 && m_slot[0] == 2 && m_pos[0] == 0)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL drop_blank_wait timeout got=%0d exp<200", k);
        end
        run = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL drop_blank cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
            if (en && sel == 2'd2) slot2_en++;
        end
        checks++;
        if (slot2_en != 0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL drop_blank_slot2 got en_cycles=%0d sel=%0d exp 0 and 0", slot2_en, sel);
        end
    endtask

    task automatic test_fast();
        int last_fd, en_low;
        last_fd = -1; en_low = 0;
        mask = 4'hF;
        run  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL fast cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
            if (k >= 2 && !f_en) en_low++;
            if (f_fd) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (cyc - last_fd != 4 * (B1 + A1)) begin
                        errors++;
                        $display("FAIL fast_frame_period got=%0d exp=%0d", cyc - last_fd, 4 * (B1 + A1));
                    end
                end
                last_fd = cyc;
            end
        end
        checks++;
        if (en_low != 0) begin
            errors++;
            $display("FAIL fast_en_continuous low_cycles=%0d exp=0", en_low);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        while (k < 200 && !(m_on[0] != 0 && m_slot[0] == 3 && m_pos[0] == B0 + 2)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL reset_mid_wait timeout got=%0d exp<200", k);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_async got=%b exp=%b", {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_restart cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            checks++;
            if ({sel, en, dd, fd, f_sel, f_en, f_dd, f_fd} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {sel, en, dd, fd, f_sel, f_en, f_dd, f_fd}, exp_vec());
            end
            mask = 4'($urandom);
            if ($urandom_range(0, 19) == 0) run = ~run;
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_masked();
        test_run_drop_active();
        test_run_drop_blank();
        test_fast();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
